// File: rtl/sip_pkg.sv
// Shared types and constants for the SIP frame feeder.
package sip_pkg;

    localparam int unsigned N_SYN_DEF  = 16;
    localparam int unsigned W_BITS_DEF = 4;

    // Bit positions inside the three-field pending/request vector
    localparam int unsigned N_FIELDS     = 3;
    localparam int unsigned FIELD_WEIGHT = 0;
    localparam int unsigned FIELD_EIN    = 1;
    localparam int unsigned FIELD_SPIKE  = 2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } feed_state_t;

endpackage

// File: rtl/sip_frame_feeder_if.sv
// Stream-in, flush-request and parallel-frame-out bundle of the SIP frame feeder.
interface sip_frame_feeder_if
    import sip_pkg::*;
#(
    parameter int unsigned N_SYN  = N_SYN_DEF,
    parameter int unsigned W_BITS = W_BITS_DEF
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [W_BITS-1:0]             in_weight;
    logic                          in_spike;
    logic                          in_ein;
    logic                          in_last;
    logic                          flush_weight;
    logic                          flush_Ein;
    logic                          flush_spike;
    logic [N_SYN-1:0][W_BITS-1:0]  parallel_in_weight;
    logic [N_SYN-1:0]              parallel_spike_in;
    logic [N_SYN-1:0]              parallel_Ein;
    logic                          load;
    logic                          frame_err;

    // master: stream source and SIP requester; slave: the feeder
    modport master (
        output in_valid, in_weight, in_spike, in_ein, in_last,
               flush_weight, flush_Ein, flush_spike,
        input  in_ready, parallel_in_weight, parallel_spike_in, parallel_Ein,
               load, frame_err
    );

    modport slave (
        input  in_valid, in_weight, in_spike, in_ein, in_last,
               flush_weight, flush_Ein, flush_spike,
        output in_ready, parallel_in_weight, parallel_spike_in, parallel_Ein,
               load, frame_err
    );

endinterface

// File: rtl/sip_shadow_buffer.sv
// Shadow frame store: indexed write of one synapse entry per beat, full parallel read.
module sip_shadow_buffer
    import sip_pkg::*;
#(
    parameter int unsigned N_SYN  = N_SYN_DEF,
    parameter int unsigned W_BITS = W_BITS_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         clr,
    input  logic [W_BITS-1:0]            wr_weight,
    input  logic                         wr_spike,
    input  logic                         wr_ein,
    output logic                         at_last_c,
    output logic [N_SYN-1:0][W_BITS-1:0] rd_weight,
    output logic [N_SYN-1:0]             rd_spike,
    output logic [N_SYN-1:0]             rd_ein
);

    localparam int unsigned IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYN - 1);

    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N_SYN-1:0][W_BITS-1:0] weight_q, weight_d;
    logic [N_SYN-1:0]             spike_q, spike_d;
    logic [N_SYN-1:0]             ein_q, ein_d;

    // Clear only rewinds the index; stale entries are overwritten by the next frame
    always_comb begin
        idx_d    = idx_q;
        weight_d = weight_q;
        spike_d  = spike_q;
        ein_d    = ein_q;
        if (wr_en) begin
            weight_d[idx_q] = wr_weight;
            spike_d[idx_q]  = wr_spike;
            ein_d[idx_q]    = wr_ein;
            idx_d           = idx_q + IDX_W'(1);
        end
        if (clr) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            weight_q <= '0;
            spike_q  <= '0;
            ein_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            weight_q <= weight_d;
            spike_q  <= spike_d;
            ein_q    <= ein_d;
        end
    end

    assign at_last_c = (idx_q == LAST_IDX);
    assign rd_weight = weight_q;
    assign rd_spike  = spike_q;
    assign rd_ein    = ein_q;

endmodule

// File: rtl/sip_frame_feeder.sv
// SIP frame feeder: assembles streamed synapse entries and serves flush requests.
// Optional framing check on in_last enabled by defining SIP_FEED_FRAMECHK_EN.
module sip_frame_feeder
    import sip_pkg::*;
#(
    parameter int unsigned N_SYN  = N_SYN_DEF,
    parameter int unsigned W_BITS = W_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    sip_frame_feeder_if.slave    bus
);

    feed_state_t                  state_q, state_d;
    logic [N_FIELDS-1:0]          pend_q, pend_d;
    logic                         ready_q, ready_d;
    logic                         load_q, load_d;
    logic                         err_q, err_d;
    logic [N_SYN-1:0][W_BITS-1:0] pw_q, pw_d;
    logic [N_SYN-1:0]             ps_q, ps_d;
    logic [N_SYN-1:0]             pe_q, pe_d;

    logic                         accept_c;
    logic                         last_beat_c;
    logic                         frame_bad_c;
    logic                         wr_en_c;
    logic                         clr_c;
    logic [N_FIELDS-1:0]          flush_c;
    logic [N_FIELDS-1:0]          req_c;
    logic [N_SYN-1:0][W_BITS-1:0] sh_weight;
    logic [N_SYN-1:0]             sh_spike;
    logic [N_SYN-1:0]             sh_ein;

    sip_shadow_buffer #(
        .N_SYN  (N_SYN),
        .W_BITS (W_BITS)
    ) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en_c),
        .clr       (clr_c),
        .wr_weight (bus.in_weight),
        .wr_spike  (bus.in_spike),
        .wr_ein    (bus.in_ein),
        .at_last_c (last_beat_c),
        .rd_weight (sh_weight),
        .rd_spike  (sh_spike),
        .rd_ein    (sh_ein)
    );

    assign accept_c = bus.in_valid && ready_q;

`ifdef SIP_FEED_FRAMECHK_EN
    // in_last must coincide exactly with the final index of the frame
    assign frame_bad_c = accept_c && (bus.in_last != last_beat_c);
`else
    logic unused_last_c;
    assign unused_last_c = bus.in_last;
    assign frame_bad_c   = 1'b0;
`endif

    always_comb begin
        flush_c               = '0;
        flush_c[FIELD_WEIGHT] = bus.flush_weight;
        flush_c[FIELD_EIN]    = bus.flush_Ein;
        flush_c[FIELD_SPIKE]  = bus.flush_spike;
    end

    // Next-state, pending and output-register logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | flush_c;
        req_c   = pend_q | flush_c;
        load_d  = 1'b0;
        err_d   = 1'b0;
        pw_d    = pw_q;
        ps_d    = ps_q;
        pe_d    = pe_q;
        wr_en_c = 1'b0;
        clr_c   = 1'b0;

        case (state_q)
            FILL: begin
                wr_en_c = accept_c;
                if (frame_bad_c) begin
                    err_d = 1'b1;
                    clr_c = 1'b1;
                end else if (accept_c && last_beat_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // A flush seen in this cycle is served here, not re-latched
                if (req_c != '0) begin
                    if (req_c[FIELD_WEIGHT]) pw_d = sh_weight;
                    if (req_c[FIELD_EIN])    pe_d = sh_ein;
                    if (req_c[FIELD_SPIKE])  ps_d = sh_spike;
                    pend_d  = '0;
                    load_d  = 1'b1;
                    clr_c   = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        ready_d = (state_d == FILL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            pend_q  <= '0;
            ready_q <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            pw_q    <= '0;
            ps_q    <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            load_q  <= load_d;
            err_q   <= err_d;
            pw_q    <= pw_d;
            ps_q    <= ps_d;
            pe_q    <= pe_d;
        end
    end

    assign bus.in_ready           = ready_q;
    assign bus.load               = load_q;
    assign bus.frame_err          = err_q;
    assign bus.parallel_in_weight = pw_q;
    assign bus.parallel_spike_in  = ps_q;
    assign bus.parallel_Ein       = pe_q;

endmodule

// File: tb/tb_sip_frame_feeder.sv
// Scoreboard bench for sip_frame_feeder: directed frames, monitor checks every load.
module tb_sip_frame_feeder;
    import sip_pkg::*;

    localparam int unsigned NS = 16;
    localparam int unsigned WB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sip_frame_feeder_if #(.N_SYN(NS), .W_BITS(WB)) bus ();

    sip_frame_feeder #(.N_SYN(NS), .W_BITS(WB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NS-1:0][WB-1:0] w;
        logic [NS-1:0]         s;
        logic [NS-1:0]         e;
    } frame_t;

    frame_t exp_q[$];
    frame_t model;
    frame_t mon_exp;

    int n_cmp = 0;
    int n_bad = 0;
    int n_load = 0;
    int n_err = 0;
    int exp_loads = 0;
    int exp_errs = 0;
    int hi_cnt;

    logic [NS-1:0][WB-1:0] fw;
    logic [NS-1:0]         fs;
    logic [NS-1:0]         fe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Update the presented-output model for the requested fields and queue it
    task automatic push_exp(input logic [2:0] mask);
        if (mask[FIELD_WEIGHT]) model.w = fw;
        if (mask[FIELD_EIN])    model.e = fe;
        if (mask[FIELD_SPIKE])  model.s = fs;
        exp_q.push_back(model);
        exp_loads++;
    endtask

    // Stream nbeats entries from fw/fs/fe; fmask is pulsed alongside beat flush_at
    task automatic drive_beats(input int nbeats, input int last_at,
                               input logic [2:0] fmask, input int flush_at);
        for (int i = 0; i < nbeats; i++) begin
            int t;
            t = 0;
            @(negedge clock);
            while (bus.in_ready !== 1'b1 && t < 50) begin
                @(negedge clock);
                t++;
            end
            if (t >= 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ready_timeout: in_ready=%b, expected 1 within 50 cycles", bus.in_ready);
            end
            bus.in_valid  = 1'b1;
            bus.in_weight = fw[i];
            bus.in_spike  = fs[i];
            bus.in_ein    = fe[i];
            bus.in_last   = (i == last_at);
            {bus.flush_spike, bus.flush_Ein, bus.flush_weight} = (i == flush_at) ? fmask : 3'b000;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        {bus.flush_spike, bus.flush_Ein, bus.flush_weight} = 3'b000;
    endtask

    // Monitor: every load pops one expected frame
    initial begin
        forever begin
            @(negedge clock);
            if (bus.frame_err === 1'b1) n_err++;
            if (bus.load === 1'b1) begin
                n_load++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load: got load=1, expected no load");
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("load_weight", 64'(bus.parallel_in_weight), 64'(mon_exp.w));
                    chk("load_spike",  64'(bus.parallel_spike_in),  64'(mon_exp.s));
                    chk("load_ein",    64'(bus.parallel_Ein),       64'(mon_exp.e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_weight = '0; bus.in_spike = 1'b0;
        bus.in_ein = 1'b0; bus.in_last = 1'b0;
        bus.flush_weight = 1'b0; bus.flush_Ein = 1'b0; bus.flush_spike = 1'b0;
        model = '0;
        repeat (3) @(negedge clock);

        chk("rst_ready",  64'(bus.in_ready), 64'(0));
        chk("rst_load",   64'(bus.load), 64'(0));
        chk("rst_err",    64'(bus.frame_err), 64'(0));
        chk("rst_weight", 64'(bus.parallel_in_weight), 64'(0));
        chk("rst_spike",  64'(bus.parallel_spike_in), 64'(0));
        chk("rst_ein",    64'(bus.parallel_Ein), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_release", 64'(bus.in_ready), 64'(1));

        // Frame 1: all three flushes latched during FILL
        for (int i = 0; i < NS; i++) fw[i] = WB'(i);
        fs = 16'hAAAA; fe = 16'hFFFF;
        push_exp(3'b111);
        drive_beats(NS, NS-1, 3'b111, 3);
        chk("full_ready_low", 64'(bus.in_ready), 64'(0));
        chk("full_no_load_yet", 64'(bus.load), 64'(0));
        @(negedge clock);
        chk("f1_load", 64'(bus.load), 64'(1));

        // Frame 2: spike only
        for (int i = 0; i < NS; i++) fw[i] = WB'(2 * i);
        fs = 16'h5555; fe = 16'hAAAA;
        push_exp(3'b100);
        drive_beats(NS, NS-1, 3'b100, 5);
        @(negedge clock);
        chk("f2_load", 64'(bus.load), 64'(1));

        // Frame 3: held in FULL for 20 cycles, then flush_weight
        for (int i = 0; i < NS; i++) fw[i] = WB'(15 - i);
        fs = 16'h0F0F; fe = 16'h00FF;
        drive_beats(NS, NS-1, 3'b000, -1);
        hi_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.in_ready !== 1'b0) hi_cnt++;
        end
        chk("hold_ready_cycles", 64'(hi_cnt), 64'(0));
        push_exp(3'b001);
        bus.flush_weight = 1'b1;
        @(negedge clock);
        bus.flush_weight = 1'b0;
        chk("f3_late_load", 64'(bus.load), 64'(1));

        // Frame 4: flush_Ein only in the transfer cycle
        for (int i = 0; i < NS; i++) fw[i] = WB'(i ^ 5);
        fs = 16'h1234; fe = 16'h4321;
        drive_beats(NS, NS-1, 3'b000, -1);
        push_exp(3'b010);
        bus.flush_Ein = 1'b1;
        @(negedge clock);
        bus.flush_Ein = 1'b0;
        chk("f4_load", 64'(bus.load), 64'(1));

        // Frame 5: no fresh flush, so it must wait in FULL
        for (int i = 0; i < NS; i++) fw[i] = WB'(i + 3);
        fs = 16'hBEEF; fe = 16'hCAFE;
        drive_beats(NS, NS-1, 3'b000, -1);
        repeat (5) @(negedge clock);
        chk("f5_waits_ready", 64'(bus.in_ready), 64'(0));
        push_exp(3'b101);
        bus.flush_weight = 1'b1; bus.flush_spike = 1'b1;
        @(negedge clock);
        bus.flush_weight = 1'b0; bus.flush_spike = 1'b0;
        chk("f5_load", 64'(bus.load), 64'(1));

        // Reset after 7 beats of a partial frame
        for (int i = 0; i < NS; i++) fw[i] = WB'(9);
        fs = 16'hFFFF; fe = 16'hFFFF;
        drive_beats(7, -1, 3'b111, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready",  64'(bus.in_ready), 64'(0));
        chk("mid_rst_weight", 64'(bus.parallel_in_weight), 64'(0));
        chk("mid_rst_spike",  64'(bus.parallel_spike_in), 64'(0));
        chk("mid_rst_ein",    64'(bus.parallel_Ein), 64'(0));
        model = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ready_release", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < NS; i++) fw[i] = WB'(i * 3);
        fs = 16'hF00F; fe = 16'h0FF0;
        push_exp(3'b111);
        drive_beats(NS, NS-1, 3'b111, 0);
        @(negedge clock);
        chk("post_rst_load", 64'(bus.load), 64'(1));

`ifdef SIP_FEED_FRAMECHK_EN
        // Early in_last on beat 9: error pulse, pending weight flush survives
        for (int i = 0; i < NS; i++) fw[i] = WB'(1);
        drive_beats(10, 9, 3'b001, 2);
        chk("err_pulse", 64'(bus.frame_err), 64'(1));
        chk("err_ready", 64'(bus.in_ready), 64'(1));
        exp_errs = 1;
        for (int i = 0; i < NS; i++) fw[i] = WB'(NS - 1 - i);
        push_exp(3'b001);
        drive_beats(NS, NS-1, 3'b000, -1);
        @(negedge clock);
        chk("after_err_load", 64'(bus.load), 64'(1));
`endif

        repeat (3) @(negedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("load_count", 64'(n_load), 64'(exp_loads));
        chk("err_count", 64'(n_err), 64'(exp_errs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
